// File: rtl/pc_stack.sv
// Program counter with return-address stack: inc, load, branch, call, ret.
// Optional PC_STACK_TRAP_EN redirects stack faults to TRAP_VECTOR and adds a trap pulse.
module pc_stack #(
  parameter int BUS_WIDTH    = 16,
  parameter int OFFSET_WIDTH = 8,
  parameter int STACK_DEPTH  = 8,
  parameter     RESET_VECTOR = 0,
  parameter     TRAP_VECTOR  = 16'hFFF0
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               inc,
  input  logic                               load,
  input  logic [BUS_WIDTH-1:0]               in,
  input  logic                               branch,
  input  logic [OFFSET_WIDTH-1:0]            offset,
  input  logic                               call,
  input  logic                               ret,
  output logic [BUS_WIDTH-1:0]               out,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               empty,
  output logic                               full,
  output logic                               overflow,
  output logic                               underflow
`ifdef PC_STACK_TRAP_EN
  ,
  output logic                               trap
`endif
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [BUS_WIDTH-1:0] RST_PC = BUS_WIDTH'(RESET_VECTOR);
  localparam logic [DW-1:0] FULL_D = DW'(STACK_DEPTH);

  if (OFFSET_WIDTH > BUS_WIDTH || OFFSET_WIDTH < 1 ||
      STACK_DEPTH < 1 ||
      (RESET_VECTOR >> BUS_WIDTH) != 0 ||
      (TRAP_VECTOR >> BUS_WIDTH) != 0) begin : g_bad_cfg
    $error("pc_stack: illegal parameter combination");
  end

  logic [BUS_WIDTH-1:0] r_pc;
  logic [BUS_WIDTH-1:0] r_stack [STACK_DEPTH];
  logic [DW-1:0]        r_depth;
  logic                 r_ovf;
  logic                 r_unf;

  logic                 w_do_ret;
  logic                 w_do_call;
  logic                 w_do_load;
  logic                 w_do_branch;
  logic                 w_do_inc;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_ovf_evt;
  logic                 w_unf_evt;
  logic [AW-1:0]        w_wr_idx;
  logic [AW-1:0]        w_rd_idx;
  logic [BUS_WIDTH-1:0] w_pc_inc;
  logic [BUS_WIDTH-1:0] w_pc_br;
  logic [BUS_WIDTH-1:0] w_call_fault_pc;
  logic [BUS_WIDTH-1:0] w_ret_fault_pc;
  logic [BUS_WIDTH-1:0] w_pc_nxt;

  // Fixed priority: ret > call > load > branch > inc.
  assign w_do_ret    = ret;
  assign w_do_call   = call & ~ret;
  assign w_do_load   = load & ~ret & ~call;
  assign w_do_branch = branch & ~ret & ~call & ~load;
  assign w_do_inc    = inc & ~ret & ~call & ~load & ~branch;

  assign w_empty   = (r_depth == '0);
  assign w_full    = (r_depth == FULL_D);
  assign w_push    = w_do_call & ~w_full;
  assign w_pop     = w_do_ret & ~w_empty;
  assign w_ovf_evt = w_do_call & w_full;
  assign w_unf_evt = w_do_ret & w_empty;

  // Top-of-stack index wraps correctly even when STACK_DEPTH is 2^AW.
  assign w_wr_idx = r_depth[AW-1:0];
  assign w_rd_idx = w_wr_idx - AW'(1);

  assign w_pc_inc = r_pc + BUS_WIDTH'(1);
  assign w_pc_br  = r_pc + BUS_WIDTH'($signed(offset));

`ifdef PC_STACK_TRAP_EN
  localparam logic [BUS_WIDTH-1:0] TRAP_PC = BUS_WIDTH'(TRAP_VECTOR);
  assign w_call_fault_pc = TRAP_PC;
  assign w_ret_fault_pc  = TRAP_PC;
`else
  assign w_call_fault_pc = in;
  assign w_ret_fault_pc  = w_pc_inc;
`endif

  always_comb begin
    w_pc_nxt = r_pc;
    unique case (1'b1)
      w_do_ret:
        w_pc_nxt = w_empty ? w_ret_fault_pc
                           : r_stack[w_rd_idx];
      w_do_call:
        w_pc_nxt = w_full ? w_call_fault_pc : in;
      w_do_load:   w_pc_nxt = in;
      w_do_branch: w_pc_nxt = w_pc_br;
      w_do_inc:    w_pc_nxt = w_pc_inc;
      default:     w_pc_nxt = r_pc;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc    <= RST_PC;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_push) begin
        r_depth <= r_depth + DW'(1);
      end else if (w_pop) begin
        r_depth <= r_depth - DW'(1);
      end
      r_ovf <= r_ovf | w_ovf_evt;
      r_unf <= r_unf | w_unf_evt;
    end
  end

  // Stack storage needs no reset; entries above depth are never read.
  always_ff @(posedge clock) begin
    if (w_push && !reset) begin
      r_stack[w_wr_idx] <= w_pc_inc;
    end
  end

`ifdef PC_STACK_TRAP_EN
  logic r_trap;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_trap <= 1'b0;
    end else begin
      r_trap <= w_ovf_evt | w_unf_evt;
    end
  end

  assign trap = r_trap;
`endif

  assign out       = r_pc;
  assign depth     = r_depth;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_pc_stack.sv
// Scoreboard bench for pc_stack: one 8-deep instance (reset vector 0x0100)
// and one 2-deep instance for overflow; trap checks when PC_STACK_TRAP_EN.
module tb_pc_stack;

`ifdef PC_STACK_TRAP_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif
  localparam logic [15:0] TV = 16'hFFF0;

  localparam logic [4:0] S_HOLD = 5'b00000;
  localparam logic [4:0] S_INC  = 5'b00001;
  localparam logic [4:0] S_BR   = 5'b00010;
  localparam logic [4:0] S_LD   = 5'b00100;
  localparam logic [4:0] S_CALL = 5'b01000;
  localparam logic [4:0] S_RET  = 5'b10000;

  logic        clock = 1'b0;
  logic        reset;
  logic        inc, load, branch, call, ret;
  logic [15:0] in_v;
  logic [7:0]  offset;
  logic [15:0] out;
  logic [3:0]  depth;
  logic        empty, full, ovf, unf, trap_a;

  logic        b_call;
  logic [15:0] b_in;
  logic [15:0] b_out;
  logic [1:0]  b_depth;
  logic        b_empty, b_full, b_ovf, b_unf, trap_b;

  int errs = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [15:0] pc;
    logic [3:0]  d;
    logic        full;
    logic        ov;
    logic        un;
    logic        tr;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  always #5 clock = ~clock;

  pc_stack #(
    .BUS_WIDTH(16), .OFFSET_WIDTH(8), .STACK_DEPTH(8),
    .RESET_VECTOR(16'h0100), .TRAP_VECTOR(16'hFFF0)
  ) u_dut (
    .clock(clock), .reset(reset), .inc(inc), .load(load),
    .in(in_v), .branch(branch), .offset(offset), .call(call),
    .ret(ret), .out(out), .depth(depth), .empty(empty),
    .full(full), .overflow(ovf), .underflow(unf)
`ifdef PC_STACK_TRAP_EN
    , .trap(trap_a)
`endif
  );

  pc_stack #(
    .BUS_WIDTH(16), .OFFSET_WIDTH(8), .STACK_DEPTH(2),
    .RESET_VECTOR(0), .TRAP_VECTOR(16'hFFF0)
  ) u_dut2 (
    .clock(clock), .reset(reset), .inc(1'b0), .load(1'b0),
    .in(b_in), .branch(1'b0), .offset(8'h00), .call(b_call),
    .ret(1'b0), .out(b_out), .depth(b_depth), .empty(b_empty),
    .full(b_full), .overflow(b_ovf), .underflow(b_unf)
`ifdef PC_STACK_TRAP_EN
    , .trap(trap_b)
`endif
  );

`ifndef PC_STACK_TRAP_EN
  assign trap_a = 1'b0;
  assign trap_b = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [4:0] s,
                      input logic [15:0] tgt, input logic [7:0] off,
                      input logic [15:0] e_pc, input logic [3:0] e_d,
                      input logic e_ov, input logic e_un,
                      input logic e_tr);
    exp_t e;
    @(negedge clock);
    {ret, call, load, branch, inc} = s;
    in_v = tgt;
    offset = off;
    sb_a.push_back('{tag, e_pc, e_d, (e_d == 4'd8), e_ov, e_un, e_tr});
    @(posedge clock);
    #1;
    {ret, call, load, branch, inc} = S_HOLD;
    e = sb_a.pop_front();
    chk({e.tag, ".pc"}, 32'(out), 32'(e.pc));
    chk({e.tag, ".depth"}, 32'(depth), 32'(e.d));
    chk({e.tag, ".empty"}, 32'(empty), 32'(e.d == 4'd0));
    chk({e.tag, ".full"}, 32'(full), 32'(e.full));
    chk({e.tag, ".ovf"}, 32'(ovf), 32'(e.ov));
    chk({e.tag, ".unf"}, 32'(unf), 32'(e.un));
    if (TR) chk({e.tag, ".trap"}, 32'(trap_a), 32'(e.tr));
  endtask

  task automatic bstep(input string tag, input logic c,
                       input logic [15:0] tgt, input logic [15:0] e_pc,
                       input logic [3:0] e_d, input logic e_ov,
                       input logic e_tr);
    exp_t e;
    @(negedge clock);
    b_call = c;
    b_in = tgt;
    sb_b.push_back('{tag, e_pc, e_d, (e_d == 4'd2), e_ov, 1'b0, e_tr});
    @(posedge clock);
    #1;
    b_call = 1'b0;
    e = sb_b.pop_front();
    chk({e.tag, ".pc"}, 32'(b_out), 32'(e.pc));
    chk({e.tag, ".depth"}, 32'(b_depth), 32'(e.d));
    chk({e.tag, ".full"}, 32'(b_full), 32'(e.full));
    chk({e.tag, ".ovf"}, 32'(b_ovf), 32'(e.ov));
    chk({e.tag, ".unf"}, 32'(b_unf), 32'(e.un));
    if (TR) chk({e.tag, ".trap"}, 32'(trap_b), 32'(e.tr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] ovf_pc;
    reset = 1'b1;
    {ret, call, load, branch, inc} = S_HOLD;
    in_v = '0;
    offset = '0;
    b_call = 1'b0;
    b_in = '0;
    #2;
    chk("rst.pc", 32'(out), 32'h0100);
    chk("rst.depth", 32'(depth), 32'd0);
    chk("rst.empty", 32'(empty), 32'd1);
    chk("rst.flags", 32'({ovf, unf}), 32'd0);
    chk("rst.b_pc", 32'(b_out), 32'h0000);
    @(negedge clock);
    reset = 1'b0;

    step("inc1", S_INC, 16'h0, 8'h0, 16'h0101, 4'd0, 0, 0, 0);
    step("inc2", S_INC, 16'h0, 8'h0, 16'h0102, 4'd0, 0, 0, 0);
    step("inc3", S_INC, 16'h0, 8'h0, 16'h0103, 4'd0, 0, 0, 0);
    step("ld40", S_LD, 16'h0040, 8'h0, 16'h0040, 4'd0, 0, 0, 0);
    step("brneg", S_BR, 16'h0, 8'hF0, 16'h0030, 4'd0, 0, 0, 0);
    step("ldff", S_LD, 16'hFFFF, 8'h0, 16'hFFFF, 4'd0, 0, 0, 0);
    step("wrap", S_INC, 16'h0, 8'h0, 16'h0000, 4'd0, 0, 0, 0);
    step("brpos", S_BR, 16'h0, 8'h05, 16'h0005, 4'd0, 0, 0, 0);
    step("hold", S_HOLD, 16'h0, 8'h0, 16'h0005, 4'd0, 0, 0, 0);
    step("prio_ld", S_LD | S_BR | S_INC, 16'h1234, 8'h01,
         16'h1234, 4'd0, 0, 0, 0);

    step("ld10", S_LD, 16'h0010, 8'h0, 16'h0010, 4'd0, 0, 0, 0);
    step("call1", S_CALL, 16'h0200, 8'h0, 16'h0200, 4'd1, 0, 0, 0);
    step("call2", S_CALL, 16'h0300, 8'h0, 16'h0300, 4'd2, 0, 0, 0);
    step("ret1", S_RET, 16'h0, 8'h0, 16'h0201, 4'd1, 0, 0, 0);
    step("ret2", S_RET, 16'h0, 8'h0, 16'h0011, 4'd0, 0, 0, 0);

    @(negedge clock);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    chk("pulse.pc", 32'(out), 32'h0100);

    step("unf", S_RET, 16'h0, 8'h0, TR ? TV : 16'h0101, 4'd0, 0, 1, 1);
    step("ld554", S_LD, 16'h0554, 8'h0, 16'h0554, 4'd0, 0, 1, 0);
    step("call800", S_CALL, 16'h0800, 8'h0, 16'h0800, 4'd1, 0, 1, 0);
    step("prio_ret", S_RET | S_CALL | S_INC, 16'h0900, 8'h0,
         16'h0555, 4'd0, 0, 1, 0);
    step("nopush", S_RET, 16'h0, 8'h0, TR ? TV : 16'h0556, 4'd0, 0, 1, 1);

    for (int i = 0; i < 8; i++) begin
      step($sformatf("fill%0d", i), S_CALL, 16'h1000 + 16'(i), 8'h0,
           16'h1000 + 16'(i), 4'(i + 1), 0, 1, 0);
    end
    ovf_pc = TR ? TV : 16'h2000;
    step("ovf", S_CALL, 16'h2000, 8'h0, ovf_pc, 4'd8, 1, 1, 1);
    step("ret_top", S_RET, 16'h0, 8'h0, 16'h1007, 4'd7, 1, 1, 0);

    @(negedge clock);
    call = 1'b1;
    in_v = 16'h3333;
    #2;
    reset = 1'b1;
    #1;
    chk("async.pc", 32'(out), 32'h0100);
    chk("async.depth", 32'(depth), 32'd0);
    chk("async.flags", 32'({ovf, unf}), 32'd0);
    @(posedge clock);
    #1;
    chk("held.pc", 32'(out), 32'h0100);
    chk("held.depth", 32'(depth), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    call = 1'b0;
    step("post", S_INC, 16'h0, 8'h0, 16'h0101, 4'd0, 0, 0, 0);

    bstep("b_call1", 1'b1, 16'h0A00, 16'h0A00, 4'd1, 0, 0);
    bstep("b_call2", 1'b1, 16'h0B00, 16'h0B00, 4'd2, 0, 0);
    bstep("b_ovf", 1'b1, 16'h0C00, TR ? TV : 16'h0C00, 4'd2, 1, 1);
    bstep("b_hold", 1'b0, 16'h0, TR ? TV : 16'h0C00, 4'd2, 1, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Next-generation program counter for the CPU datapath.
- Holds the current instruction address and supports:
  - reset to a configurable vector
  - increment
  - absolute load
  - PC-relative branch
  - subroutine call and return, backed by an internal return-address stack (LIFO)
- Sits between the instruction decoder (control strobes) and instruction memory (address).

Parameters:
- BUS_WIDTH, 16, address/PC width in bits.
- OFFSET_WIDTH, 8, width of the signed relative branch offset; must be at most BUS_WIDTH.
- STACK_DEPTH, 8, number of return-address entries; must be at least 1.
- RESET_VECTOR, 0, value loaded into out on reset.
- TRAP_VECTOR, 16'hFFF0, target address on a stack fault; used only with PC_STACK_TRAP_EN.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-high reset.
- inc, input, 1, out <= out + 1.
- load, input, 1, out <= in.
- in, input, BUS_WIDTH, absolute target for load and call.
- branch, input, 1, out <= out + sign-extended offset.
- offset, input, OFFSET_WIDTH, two's-complement branch displacement.
- call, input, 1, push out + 1, then out <= in.
- ret, input, 1, pop top of stack into out.
- out, output, BUS_WIDTH, current PC (registered).
- depth, output, clog2(STACK_DEPTH+1), number of valid stack entries.
- empty, output, 1, depth == 0.
- full, output, 1, depth == STACK_DEPTH.
- overflow, output, 1, sticky; call attempted while full.
- underflow, output, 1, sticky; ret attempted while empty.

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately regardless of clock):
  - out = RESET_VECTOR, depth = 0, overflow = 0, underflow = 0.
  - Stack contents are don't-care.
  - Strobes are ignored while reset is high.
  - Reset asserted mid-operation discards any pending update.
- All other updates happen on the rising clock edge; results are visible on out one cycle after the strobe.
- Exactly one action per cycle. Priority is ret > call > load > branch > inc > hold.
  - Lower-priority strobes asserted in the same cycle are ignored.
- hold (no strobe): out and stack are unchanged.
- inc: out <= out + 1, modulo 2^BUS_WIDTH. 16'hFFFF wraps to 16'h0000.
- load: out <= in.
- branch: out <= out + sext(offset), modulo 2^BUS_WIDTH.
  - The displacement is relative to the current out, not out + 1.
- call, not full:
  - stack[depth] <= out + 1 (modulo).
  - depth <= depth + 1.
  - out <= in.
- call, full:
  - No push; depth and stack are unchanged.
  - overflow <= 1.
  - out <= in without PC_STACK_TRAP_EN (the jump still occurs); out <= TRAP_VECTOR with it.
- ret, not empty:
  - out <= stack[depth-1].
  - depth <= depth - 1.
- ret, empty:
  - No pop; depth is unchanged.
  - underflow <= 1.
  - out <= out + 1 without PC_STACK_TRAP_EN; out <= TRAP_VECTOR with it.
- ret and call in the same cycle: ret wins; call is ignored entirely (no push).
- overflow and underflow stay set until reset. Further faults keep them at 1.
- empty, full and depth are combinational from the registered depth.
- STACK_DEPTH = 1: a second call while full faults as above.

Optional Feature:
- Macro: PC_STACK_TRAP_EN.
- Defined:
  - Any stack fault (call while full, ret while empty) forces out <= TRAP_VECTOR on that edge.
  - The sticky flag still sets.
  - Adds a registered output trap (1 bit): high for exactly one cycle following each fault edge, 0 at reset.
- Undefined:
  - No trap port.
  - Faults follow the non-trap rules above: call still jumps; ret acts as inc.
  - TRAP_VECTOR is unused.

Test Plan:
- Reset and increment:
  - Stimulus: reset=1 with RESET_VECTOR=16'h0100, release, then inc for 3 cycles.
  - Required: out = 16'h0100, 16'h0101, 16'h0102, 16'h0103; depth = 0; empty = 1.
- Branch and increment wrap:
  - Stimulus: load in = 16'h0040; branch offset = 8'hF0 (-16); then load in = 16'hFFFF and inc.
  - Required: out = 16'h0040, then 16'h0030, then 16'hFFFF, then 16'h0000.
- Nested call and return:
  - Stimulus: out = 16'h0010; call in = 16'h0200; call in = 16'h0300; ret; ret.
  - Required: out = 16'h0200 (depth 1), 16'h0300 (depth 2), 16'h0201 (depth 1), 16'h0011 (depth 0).
  - Required: overflow = 0 and underflow = 0 throughout.
- Overflow with STACK_DEPTH = 2:
  - Stimulus: three calls to targets 16'h0A00, 16'h0B00, 16'h0C00.
  - Required, trap undefined: third call gives out = 16'h0C00, depth = 2, full = 1, overflow = 1.
  - Required, PC_STACK_TRAP_EN defined: third call gives out = TRAP_VECTOR and trap pulses for 1 cycle.
- Underflow and priority:
  - Stimulus: from reset, ret with out = 16'h0100.
  - Required, trap undefined: out = 16'h0101, underflow = 1.
  - Stimulus: then assert ret + call + inc together with depth = 1, top of stack = 16'h0555.
  - Required: out = 16'h0555, depth = 0, no push.
- Asynchronous reset mid-stream:
  - Stimulus: depth = 3, overflow = 1; assert reset between clock edges.
  - Required: out = RESET_VECTOR, depth = 0 and overflow = 0 immediately, before the next edge.
  - Required: a strobe held during reset has no effect.
